// File: rtl/register_file.sv
// 32 x 64-bit architectural register file: two combinational read ports, one
// write port committed on the rising edge, with index ZERO_REG hardwired to zero.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [AW-1:0]         RA,
    input  logic [AW-1:0]         RB,
    input  logic [AW-1:0]         RW,
    input  logic                  RegWr,
    input  logic [DATA_WIDTH-1:0] BusW,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  w_wr_en;

    // RegWr gates the compare, so an unknown RW with RegWr low cannot select a register
    assign w_wr_en = RegWr && (RW != ZERO_IDX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[RW] <= BusW;
        end
    end

    // Reads come straight from storage, never from BusW, so no loop through the ALU
    assign BusA = (RA == ZERO_IDX) ? '0 : r_regs[RA];
    assign BusB = (RB == ZERO_IDX) ? '0 : r_regs[RB];

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: each row drives one cycle's
// inputs and checks the combinational read ports just before that cycle's edge.
module tb_register_file;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  RA, RB, RW;
    logic        RegWr;
    logic [63:0] BusW;
    logic [63:0] BusA, BusB;

    int n_vec  = 0;
    int n_miss = 0;

    register_file #(
        .DATA_WIDTH(64),
        .NUM_REGS  (32),
        .ZERO_REG  (31)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .RA   (RA),
        .RB   (RB),
        .RW   (RW),
        .RegWr(RegWr),
        .BusW (BusW),
        .BusA (BusA),
        .BusB (BusB)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rw;
        logic [63:0] busw;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        bit          chk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic we, input logic [4:0] rw,
                                input logic [63:0] busw, input logic [4:0] ra,
                                input logic [4:0] rb, input logic [63:0] exp_a,
                                input logic [63:0] exp_b, input bit chk);
        vec_t v;
        v.rst = rst; v.we = we; v.rw = rw; v.busw = busw;
        v.ra = ra; v.rb = rb; v.exp_a = exp_a; v.exp_b = exp_b; v.chk = chk;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge Clk);
        Reset = v.rst; RegWr = v.we; RW = v.rw; BusW = v.busw; RA = v.ra; RB = v.rb;
        #1;
        if (v.chk) begin
            check($sformatf("vec[%0d] BusA RA=%0d", idx, v.ra), BusA, v.exp_a);
            check($sformatf("vec[%0d] BusB RB=%0d", idx, v.rb), BusB, v.exp_b);
        end
        $display("vec[%0d] rst=%b we=%b rw=%0d busw=%h ra=%0d rb=%0d -> A=%h B=%h",
                 idx, v.rst, v.we, v.rw, v.busw, v.ra, v.rb, BusA, BusB);
    endtask

    initial begin
        Reset = 1'b0; RegWr = 1'b0; RW = '0; RA = '0; RB = '0; BusW = '0;

        // Reset, then every address reads zero on both ports
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            add(0, 0, 0, 0, 5'(i), 5'(31 - i), 64'h0, 64'h0, 1);

        // Fill X0..X30; the row's own read shows the pre-write value
        for (int i = 0; i < 31; i++)
            add(0, 1, 5'(i), 64'h100 + 64'(i), 5'(i), 5'd31, 64'h0, 64'h0, 1);
        for (int i = 0; i < 31; i++)
            add(0, 0, 0, 0, 5'(i), 5'(30 - i), 64'h100 + 64'(i), 64'h100 + 64'(30 - i), 1);

        // Writes to XZR are dropped and leave other registers alone
        add(0, 1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 5'd31, 64'h0, 64'h0, 1);
        add(0, 0, 0, 0, 5'd31, 5'd31, 64'h0, 64'h0, 1);
        add(0, 0, 0, 0, 5'd30, 5'd29, 64'h11E, 64'h11D, 1);

        // Read-during-write to the same register shows the old value until the edge
        add(0, 1, 5'd5, 64'h1, 5'd5, 5'd6, 64'h105, 64'h106, 1);
        add(0, 1, 5'd5, 64'h2, 5'd5, 5'd5, 64'h1, 64'h1, 1);
        add(0, 0, 0, 0, 5'd5, 5'd5, 64'h2, 64'h2, 1);

        // Reset beats a simultaneous write; reads stay live during reset
        add(0, 1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 5'd0, 64'h107, 64'h100, 1);
        add(1, 1, 5'd7, 64'h5, 5'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h101, 1);
        add(0, 0, 0, 0, 5'd7, 5'd20, 64'h0, 64'h0, 1);
        add(0, 1, 5'd7, 64'h9, 5'd7, 5'd31, 64'h0, 64'h0, 1);
        add(0, 0, 0, 0, 5'd7, 5'd30, 64'h9, 64'h0, 1);

        // RegWr low ignores RW/BusW activity, including an unknown RW
        add(0, 1, 5'd3, 64'hAAAA, 5'd3, 5'd7, 64'h0, 64'h9, 1);
        for (int k = 0; k < 4; k++)
            add(0, 0, 5'd3, (k % 2 == 0) ? 64'h1234 : ~64'h1234, 5'd3, 5'd7, 64'hAAAA, 64'h9, 1);
        add(0, 0, 5'bxxxxx, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd3, 64'h0, 64'hAAAA, 1);
        add(0, 0, 0, 0, 5'd0, 5'd3, 64'h0, 64'hAAAA, 1);

        foreach (vecs[i]) apply(i, vecs[i]);

        // Hand sequence: no combinational path from BusW/RW to the read ports
        @(negedge Clk);
        Reset = 0; RegWr = 1; RW = 5'd5; BusW = 64'h1; RA = 5'd5; RB = 5'd5;
        @(negedge Clk);
        BusW = 64'h2;
        #1 check("seq pre-edge BusA", BusA, 64'h1);
        BusW = 64'h3;
        #1 check("seq BusW wiggle BusA", BusA, 64'h1);
        RW = 5'd6; RegWr = 1'b0;
        #1 check("seq RW/RegWr wiggle BusB", BusB, 64'h1);
        RW = 5'd5; RegWr = 1'b1; BusW = 64'h2;
        $display("seq bypass check: A=%h B=%h before edge", BusA, BusB);
        @(negedge Clk);
        RegWr = 1'b0;
        #1 check("seq post-edge BusA", BusA, 64'h2);
        check("seq post-edge BusB", BusB, 64'h2);
        $display("seq bypass check: A=%h B=%h after edge", BusA, BusB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
